// File: rtl/hazard_ctrl_if.sv
// Pipeline sequencing bundle: hazard sources from ID/EX/MEM plus the
// per-register stall/flush enables and performance counters.
interface hazard_ctrl_if #(
  parameter int RS_WIDTH  = 5,
  parameter int CNT_WIDTH = 16
);
  // Hazard sources
  logic [RS_WIDTH-1:0]  rs1_id;
  logic [RS_WIDTH-1:0]  rs2_id;
  logic                 rs1_used_id;
  logic                 rs2_used_id;
  logic [RS_WIDTH-1:0]  rd_ex;
  logic                 mem_read_ex;
  logic                 branch_taken_ex;
  logic                 md_start_ex;
  logic                 md_done;
  logic                 dmem_req_mem;
  logic                 dmem_ack;

  // Pipeline register controls
  logic                 pc_stall;
  logic                 if_id_stall;
  logic                 if_id_flush;
  logic                 id_ex_stall;
  logic                 id_ex_flush;
  logic                 ex_mem_stall;
  logic                 ex_mem_flush;
  logic                 mem_wb_flush;

  // Performance counters
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;

  // Core side: drives hazard sources, consumes controls
  modport master (
    output rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, mem_read_ex,
           branch_taken_ex, md_start_ex, md_done, dmem_req_mem, dmem_ack,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, ex_mem_flush, mem_wb_flush, stall_cnt, flush_cnt
  );

  // Controller side: consumes hazard sources, drives controls
  modport slave (
    input  rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, mem_read_ex,
           branch_taken_ex, md_start_ex, md_done, dmem_req_mem, dmem_ack,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, ex_mem_flush, mem_wb_flush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core. Resolves data-memory wait,
// mul/div occupancy of EX, taken-branch redirect and load-use hazards in
// strict priority order, and counts stall cycles and branch flushes.
module hazard_ctrl #(
  parameter int RS_WIDTH  = 5,
  parameter int CNT_WIDTH = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  localparam logic [RS_WIDTH-1:0]  IDX_ZERO = {RS_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic mem_wait_s;
  logic md_busy_s;
  logic load_use_s;
  logic flush_evt_s;

  logic pc_stall_s, if_id_stall_s, if_id_flush_s, id_ex_stall_s;
  logic id_ex_flush_s, ex_mem_stall_s, ex_mem_flush_s, mem_wb_flush_s;

  // Hazard condition decode shared by the priority chain
  always_comb begin
    mem_wait_s = bus.dmem_req_mem & ~bus.dmem_ack;
    // A start without a same-cycle done occupies EX from this cycle on
    md_busy_s  = (state_q == MD_WAIT) | (bus.md_start_ex & ~bus.md_done);
    // x0 is never written, so a load targeting it cannot create a hazard
    load_use_s = bus.mem_read_ex & (bus.rd_ex != IDX_ZERO) &
                 ((bus.rs1_used_id & (bus.rs1_id == bus.rd_ex)) |
                  (bus.rs2_used_id & (bus.rs2_id == bus.rd_ex)));
  end

  // Mul/div occupancy tracking; keeps watching md_done even during mem wait
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (bus.md_start_ex && !bus.md_done) begin
          state_d = MD_WAIT;
        end else begin
          state_d = RUN;
        end
      end
      MD_WAIT: begin
        // A new start while busy is ignored; only done releases EX
        if (bus.md_done) begin
          state_d = RUN;
        end else begin
          state_d = MD_WAIT;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Prioritised stall/flush selection; reset fills the pipe with bubbles
  always_comb begin
    pc_stall_s     = 1'b0;
    if_id_stall_s  = 1'b0;
    if_id_flush_s  = 1'b0;
    id_ex_stall_s  = 1'b0;
    id_ex_flush_s  = 1'b0;
    ex_mem_stall_s = 1'b0;
    ex_mem_flush_s = 1'b0;
    mem_wb_flush_s = 1'b0;
    flush_evt_s    = 1'b0;
    if (rst) begin
      if_id_flush_s  = 1'b1;
      id_ex_flush_s  = 1'b1;
      ex_mem_flush_s = 1'b1;
      mem_wb_flush_s = 1'b1;
    end else if (mem_wait_s) begin
      // Whole front of the pipe freezes; MEM/WB gets bubbles
      pc_stall_s     = 1'b1;
      if_id_stall_s  = 1'b1;
      id_ex_stall_s  = 1'b1;
      ex_mem_stall_s = 1'b1;
      mem_wb_flush_s = 1'b1;
    end else if (md_busy_s) begin
      // EX holds its operands; bubbles flow into MEM
      pc_stall_s     = 1'b1;
      if_id_stall_s  = 1'b1;
      id_ex_stall_s  = 1'b1;
      ex_mem_flush_s = 1'b1;
    end else if (bus.branch_taken_ex) begin
      // Squash the wrong-path instructions; any load-use in ID is moot
      if_id_flush_s  = 1'b1;
      id_ex_flush_s  = 1'b1;
      flush_evt_s    = 1'b1;
    end else if (load_use_s) begin
      // One bubble suffices: it clears mem_read_ex next cycle
      pc_stall_s     = 1'b1;
      if_id_stall_s  = 1'b1;
      id_ex_flush_s  = 1'b1;
    end else begin
      pc_stall_s     = 1'b0;
    end
  end

  // Saturating performance counter next-state
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall_s && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_evt_s && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= {CNT_WIDTH{1'b0}};
      flush_cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pc_stall     = pc_stall_s;
  assign bus.if_id_stall  = if_id_stall_s;
  assign bus.if_id_flush  = if_id_flush_s;
  assign bus.id_ex_stall  = id_ex_stall_s;
  assign bus.id_ex_flush  = id_ex_flush_s;
  assign bus.ex_mem_stall = ex_mem_stall_s;
  assign bus.ex_mem_flush = ex_mem_flush_s;
  assign bus.mem_wb_flush = mem_wb_flush_s;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a reference model pushes expected
// control vectors as stimulus is applied; they are popped and compared
// against the DUT mid-cycle. Counters use a narrow width to reach saturation.
module tb_hazard_ctrl;
  localparam int RS_W    = 5;
  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Control vector order:
  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
  //  ex_mem_stall, ex_mem_flush, mem_wb_flush}
  localparam logic [7:0] V_RST  = 8'b0010_1011;
  localparam logic [7:0] V_MEM  = 8'b1101_0101;
  localparam logic [7:0] V_MD   = 8'b1101_0010;
  localparam logic [7:0] V_BR   = 8'b0010_1000;
  localparam logic [7:0] V_LU   = 8'b1100_1000;
  localparam logic [7:0] V_NONE = 8'b0000_0000;

  typedef struct {
    string      tag;
    logic [7:0] vec;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb_q[$];
  int   n_total;
  int   n_bad;

  // Reference model state
  bit   m_wait;
  int   m_scnt;
  int   m_fcnt;

  hazard_ctrl_if #(.RS_WIDTH(RS_W), .CNT_WIDTH(CNT_W)) bus ();

  hazard_ctrl #(.RS_WIDTH(RS_W), .CNT_WIDTH(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] dut_vec();
    return {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_ex_stall,
            bus.id_ex_flush, bus.ex_mem_stall, bus.ex_mem_flush, bus.mem_wb_flush};
  endfunction

  function automatic logic [7:0] model_vec();
    bit lu;
    lu = bus.mem_read_ex && (bus.rd_ex != 5'd0) &&
         ((bus.rs1_used_id && bus.rs1_id == bus.rd_ex) ||
          (bus.rs2_used_id && bus.rs2_id == bus.rd_ex));
    if (rst) return V_RST;
    if (bus.dmem_req_mem && !bus.dmem_ack) return V_MEM;
    if (m_wait || (bus.md_start_ex && !bus.md_done)) return V_MD;
    if (bus.branch_taken_ex) return V_BR;
    if (lu) return V_LU;
    return V_NONE;
  endfunction

  task automatic model_reset();
    m_wait = 1'b0;
    m_scnt = 0;
    m_fcnt = 0;
  endtask

  task automatic model_edge(input logic [7:0] v);
    if (rst) begin
      model_reset();
    end else begin
      if (v[7] && m_scnt < CNT_MAX) m_scnt++;
      if (v == V_BR && m_fcnt < CNT_MAX) m_fcnt++;
      if (m_wait) begin
        if (bus.md_done) m_wait = 1'b0;
      end else if (bus.md_start_ex && !bus.md_done) begin
        m_wait = 1'b1;
      end
    end
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag = tag;
    e.vec = model_vec();
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, {24'd0, dut_vec()}, {24'd0, e.vec});
    end
  endtask

  // One clock cycle with the currently driven inputs
  task automatic step(input string tag);
    logic [7:0] v;
    v = model_vec();
    push_exp(tag);
    @(negedge clk);
    pop_cmp();
    check_val({tag, "_scnt"}, 32'(bus.stall_cnt), 32'(m_scnt));
    check_val({tag, "_fcnt"}, 32'(bus.flush_cnt), 32'(m_fcnt));
    @(posedge clk);
    model_edge(v);
    #1;
  endtask

  task automatic set_idle();
    bus.rs1_id          = 5'd0;
    bus.rs2_id          = 5'd0;
    bus.rs1_used_id     = 1'b0;
    bus.rs2_used_id     = 1'b0;
    bus.rd_ex           = 5'd0;
    bus.mem_read_ex     = 1'b0;
    bus.branch_taken_ex = 1'b0;
    bus.md_start_ex     = 1'b0;
    bus.md_done         = 1'b0;
    bus.dmem_req_mem    = 1'b0;
    bus.dmem_ack        = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    model_reset();
    rst = 1'b1;
    set_idle();
    #2;
    step("rst0");
    step("rst1");
    rst = 1'b0;
    step("idle");

    // Load-use on rs1: one stall, then the bubble clears the load
    bus.mem_read_ex = 1'b1; bus.rd_ex = 5'd5;
    bus.rs1_id = 5'd5; bus.rs1_used_id = 1'b1;
    step("lu_stall");
    set_idle();
    step("lu_after");
    check_val("lu_scnt", 32'(bus.stall_cnt), 32'd1);

    // rd_ex = x0 never hazards
    bus.mem_read_ex = 1'b1; bus.rd_ex = 5'd0;
    bus.rs1_id = 5'd0; bus.rs1_used_id = 1'b1;
    step("lu_x0");
    // Matching rs2 that is not read is not a hazard
    set_idle();
    bus.mem_read_ex = 1'b1; bus.rd_ex = 5'd7;
    bus.rs2_id = 5'd7; bus.rs2_used_id = 1'b0;
    step("lu_rs2_unused");
    // Matching rs2 that is read is a hazard
    bus.rs2_used_id = 1'b1;
    step("lu_rs2");
    set_idle();

    // Mul/div: start, two busy cycles, done -> four stall cycles
    bus.md_start_ex = 1'b1;
    step("md_start");
    bus.md_start_ex = 1'b0;
    step("md_w1");
    bus.md_start_ex = 1'b1;      // ignored while busy
    step("md_w2");
    bus.md_start_ex = 1'b0; bus.md_done = 1'b1;
    step("md_done");
    bus.md_done = 1'b0;
    step("md_run");
    check_val("md_scnt", 32'(bus.stall_cnt), 32'd6);
    // Single-cycle op: start and done together
    bus.md_start_ex = 1'b1; bus.md_done = 1'b1;
    step("md_1cyc");
    set_idle();
    step("md_1cyc_after");

    // Branch beats a simultaneous load-use
    bus.branch_taken_ex = 1'b1; bus.mem_read_ex = 1'b1; bus.rd_ex = 5'd9;
    bus.rs1_id = 5'd9; bus.rs1_used_id = 1'b1;
    step("br_lu");
    set_idle();
    step("br_after");
    check_val("br_fcnt", 32'(bus.flush_cnt), 32'd1);
    check_val("br_scnt", 32'(bus.stall_cnt), 32'd6);

    // Mem wait during MD_WAIT; md_done lands inside the wait
    bus.md_start_ex = 1'b1;
    step("mw_start");
    bus.md_start_ex = 1'b0; bus.dmem_req_mem = 1'b1;
    step("mw_1");
    bus.md_done = 1'b1;
    step("mw_2_done");
    bus.md_done = 1'b0;
    step("mw_3");
    bus.dmem_ack = 1'b1;
    step("mw_ack_run");
    set_idle();
    check_val("mw_scnt", 32'(bus.stall_cnt), 32'd10);

    // Async reset in the middle of MD_WAIT
    bus.md_start_ex = 1'b1;
    step("ar_start");
    bus.md_start_ex = 1'b0;
    step("ar_w1");
    rst = 1'b1;
    #1;
    model_reset();
    push_exp("ar_rst_out");
    pop_cmp();
    check_val("ar_scnt0", 32'(bus.stall_cnt), 32'd0);
    check_val("ar_fcnt0", 32'(bus.flush_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step("ar_run");

    // Stall counter saturation through a long mem wait
    bus.dmem_req_mem = 1'b1;
    for (int i = 0; i < CNT_MAX + 6; i++) step("sat_mw");
    check_val("scnt_sat", 32'(bus.stall_cnt), 32'(CNT_MAX));
    set_idle();
    // Flush counter saturation through back-to-back redirects
    bus.branch_taken_ex = 1'b1;
    for (int i = 0; i < CNT_MAX + 6; i++) step("sat_br");
    set_idle();
    check_val("fcnt_sat", 32'(bus.flush_cnt), 32'(CNT_MAX));
    step("final");

    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
